barrido_display: RTL and testbench

//  Time-multiplexes an N-digit hex value onto a shared 7-segment bus.

---
 rtl/barrido_display_if.sv | 23 ++
 rtl/barrido_display.sv | 81 ++++++++
 tb/tb_barrido_display.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/barrido_display_if.sv
// Digit-scan bus between the value source and the 7-segment scanner.
// The master supplies the value and controls; the slave returns the digit being shown.
interface barrido_display_if #(
  parameter int NUM_DIGITOS = 4
);
  logic [4*NUM_DIGITOS-1:0] valor;
  logic                     cargar;
  logic                     supr_ceros;
  logic [3:0]               nibble;
  logic [NUM_DIGITOS-1:0]   anodos;
  logic [2:0]               indice;
  logic                     tick_digito;

  modport master (
    output valor, cargar, supr_ceros,
    input  nibble, anodos, indice, tick_digito
  );

  modport slave (
    input  valor, cargar, supr_ceros,
    output nibble, anodos, indice, tick_digito
  );
endinterface

// File: rtl/barrido_display.sv
// Time-multiplexed scan of an N-digit hex value onto a shared 7-segment bus,
// with active-low anodes and optional leading-zero blanking.
module barrido_display #(
  parameter int NUM_DIGITOS  = 4,
  parameter int DIV_REFRESCO = 50000
) (
  input  logic               clk,
  input  logic               rst,
  barrido_display_if.slave   bus
);
  localparam int             CW       = $clog2(DIV_REFRESCO + 1);
  localparam logic [CW-1:0]  CONT_MAX = CW'(DIV_REFRESCO - 1);
  localparam logic [2:0]     IDX_MAX  = 3'(NUM_DIGITOS - 1);

  typedef enum logic {
    ST_APAGADO,
    ST_ACTIVO
  } estado_t;

  estado_t                  estado, estado_sig;
  logic [4*NUM_DIGITOS-1:0] valor_reg;
  logic [4*NUM_DIGITOS-1:0] superior;
  logic [CW-1:0]            cont;
  logic [2:0]               idx;
  logic                     tick;
  logic                     fin_digito;
  logic                     blanco;
  logic [NUM_DIGITOS-1:0]   anodos_c;

  assign fin_digito = (cont == CONT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= ST_APAGADO;
      valor_reg <= '0;
      cont      <= '0;
      idx       <= '0;
      tick      <= 1'b0;
    end else begin
      estado <= estado_sig;
      if (bus.cargar) begin
        valor_reg <= bus.valor;
      end
      if (fin_digito) begin
        cont <= '0;
        idx  <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
        tick <= 1'b1;
      end else begin
        cont <= cont + CW'(1);
        tick <= 1'b0;
      end
    end
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      ST_APAGADO: estado_sig = ST_ACTIVO;
      ST_ACTIVO:  estado_sig = ST_ACTIVO;
      default:    estado_sig = ST_APAGADO;
    endcase
  end

  // Shifting the current digit down to bit 0 gives both the nibble and the
  // "this digit and everything above it is zero" test in one operation.
  always_comb begin
    superior = valor_reg >> {idx, 2'b00};
    blanco   = bus.supr_ceros && (idx != 3'd0) && (superior == '0);
    anodos_c = '1;
    for (int unsigned i = 0; i < NUM_DIGITOS; i++) begin
      if ((estado == ST_ACTIVO) && !blanco && (idx == 3'(i))) begin
        anodos_c[i] = 1'b0;
      end
    end
  end

  assign bus.nibble      = superior[3:0];
  assign bus.anodos      = anodos_c;
  assign bus.indice      = idx;
  assign bus.tick_digito = tick;
endmodule

// File: tb/tb_barrido_display.sv
// Bench for barrido_display: directed vector table, hand-written corner sequences,
// and randomized traffic checked against an arithmetic scan model.
module tb_barrido_display;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  barrido_display_if #(.NUM_DIGITOS(4)) bus ();
  barrido_display_if #(.NUM_DIGITOS(1)) bus2 ();

  barrido_display #(.NUM_DIGITOS(4), .DIV_REFRESCO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  barrido_display #(.NUM_DIGITOS(1), .DIV_REFRESCO(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.valor      = bus.valor[3:0];
  assign bus2.cargar     = bus.cargar;
  assign bus2.supr_ceros = bus.supr_ceros;

  typedef struct {
    logic        r, c, s;
    logic [15:0] v;
    int unsigned rep;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic [2:0]  ind;
    logic        tk;
  } vec_t;

  typedef struct packed {
    logic [3:0] nib;
    logic [7:0] an;
    logic [2:0] ind;
    logic       tk;
  } exp_t;

  vec_t        tabla[$];
  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned k      = 0;
  logic [15:0] mval   = '0;
  logic [3:0]  mval2  = '0;

  task automatic add(input logic r, c, s, input logic [15:0] v, input int unsigned rep,
                     input logic [3:0] nib, an, input logic [2:0] ind, input logic tk);
    vec_t x;
    x.r = r; x.c = c; x.s = s; x.v = v; x.rep = rep;
    x.nib = nib; x.an = an; x.ind = ind; x.tk = tk;
    tabla.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scan position follows from the number of clocks since reset: k edges in,
  // the counter is k mod DIV and the digit is (k div DIV) mod N.
  function automatic exp_t modelo(input int unsigned kk, input logic [31:0] v, input logic s,
                                  input int unsigned n, input int unsigned div);
    exp_t        e;
    int unsigned i;
    logic [31:0] up;
    logic [7:0]  mask;
    i     = (kk / div) % n;
    up    = v >> (4 * i);
    mask  = 8'((1 << n) - 1);
    e.nib = up[3:0];
    e.ind = 3'(i);
    e.tk  = (kk >= 1) && (kk % div == 0);
    if ((kk >= 1) && !(s && (i > 0) && (up == 0))) e.an = mask & ~(8'(1) << i);
    else e.an = mask;
    return e;
  endfunction

  task automatic ciclo();
    @(posedge clk);
    if (rst) begin
      k = 0; mval = '0; mval2 = '0;
    end else begin
      if (bus.cargar) begin
        mval  = bus.valor;
        mval2 = bus.valor[3:0];
      end
      k++;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    exp_t e;
    e = modelo(k, 32'(mval), bus.supr_ceros, 4, 4);
    chk({tag, ".nibble"}, 32'(bus.nibble), 32'(e.nib));
    chk({tag, ".anodos"}, 32'(bus.anodos), 32'(e.an));
    chk({tag, ".indice"}, 32'(bus.indice), 32'(e.ind));
    chk({tag, ".tick"},   32'(bus.tick_digito), 32'(e.tk));
    e = modelo(k, 32'(mval2), bus.supr_ceros, 1, 1);
    chk({tag, "1.nibble"}, 32'(bus2.nibble), 32'(e.nib));
    chk({tag, "1.anodos"}, 32'(bus2.anodos), 32'(e.an));
    chk({tag, "1.indice"}, 32'(bus2.indice), 32'(e.ind));
    chk({tag, "1.tick"},   32'(bus2.tick_digito), 32'(e.tk));
  endtask

  task automatic chk_out(input string tag, input logic [3:0] nib, an,
                         input logic [2:0] ind, input logic tk);
    chk({tag, ".nibble"}, 32'(bus.nibble), 32'(nib));
    chk({tag, ".anodos"}, 32'(bus.anodos), 32'(an));
    chk({tag, ".indice"}, 32'(bus.indice), 32'(ind));
    chk({tag, ".tick"},   32'(bus.tick_digito), 32'(tk));
  endtask

  initial begin
    bus.valor = '0; bus.cargar = 1'b0; bus.supr_ceros = 1'b0;

    //   r  c  s  valor    rep nib an     ind tk
    add(1, 1, 0, 16'hABCD, 3, 0, 4'hF, 0, 0);  // reset overrides load
    add(0, 1, 0, 16'h1234, 1, 4, 4'hE, 0, 0);  // first cycle after release
    add(0, 0, 0, 16'h1234, 2, 4, 4'hE, 0, 0);
    add(0, 0, 0, 16'h1234, 1, 3, 4'hD, 1, 1);
    add(0, 0, 0, 16'h1234, 3, 3, 4'hD, 1, 0);
    add(0, 0, 0, 16'h1234, 1, 2, 4'hB, 2, 1);
    add(0, 0, 0, 16'h1234, 3, 2, 4'hB, 2, 0);
    add(0, 0, 0, 16'h1234, 1, 1, 4'h7, 3, 1);
    add(0, 0, 0, 16'h1234, 3, 1, 4'h7, 3, 0);
    add(0, 0, 0, 16'h1234, 1, 4, 4'hE, 0, 1);  // wrap 3 -> 0
    add(0, 0, 0, 16'h1234, 1, 4, 4'hE, 0, 0);
    add(0, 1, 1, 16'h0070, 1, 0, 4'hE, 0, 0);  // blanking: digit 0 always lit
    add(0, 0, 1, 16'h0070, 1, 0, 4'hE, 0, 0);
    add(0, 0, 1, 16'h0070, 1, 7, 4'hD, 1, 1);
    add(0, 0, 1, 16'h0070, 3, 7, 4'hD, 1, 0);
    add(0, 0, 1, 16'h0070, 1, 0, 4'hF, 2, 1);
    add(0, 0, 1, 16'h0070, 3, 0, 4'hF, 2, 0);
    add(0, 0, 1, 16'h0070, 1, 0, 4'hF, 3, 1);
    add(0, 1, 1, 16'h0000, 1, 0, 4'hF, 3, 0);
    add(0, 0, 1, 16'h0000, 2, 0, 4'hF, 3, 0);
    add(0, 0, 1, 16'h0000, 1, 0, 4'hE, 0, 1);
    add(0, 0, 1, 16'h0000, 3, 0, 4'hE, 0, 0);
    add(0, 0, 1, 16'h0000, 1, 0, 4'hF, 1, 1);
    add(0, 0, 0, 16'h0000, 1, 0, 4'hD, 1, 0);

    foreach (tabla[n]) begin
      rst = tabla[n].r; bus.cargar = tabla[n].c;
      bus.supr_ceros = tabla[n].s; bus.valor = tabla[n].v;
      for (int unsigned j = 0; j < tabla[n].rep; j++) begin
        ciclo();
        chk_out($sformatf("vec%0d", n), tabla[n].nib, tabla[n].an, tabla[n].ind, tabla[n].tk);
      end
    end

    // supr_ceros acts without a clock edge
    bus.supr_ceros = 1'b1; #1;
    chk("supr_comb.anodos", 32'(bus.anodos), 32'hF);
    bus.supr_ceros = 1'b0; #1;
    chk("supr_comb_off.anodos", 32'(bus.anodos), 32'hD);

    // Load mid-scan: value changes, scan timing does not
    rst = 1'b1; bus.cargar = 1'b0; ciclo();
    rst = 1'b0; bus.cargar = 1'b1; bus.valor = 16'h1234; ciclo();
    bus.cargar = 1'b0; repeat (8) ciclo();
    chk("t5_pre.indice", 32'(bus.indice), 32'd2);
    bus.cargar = 1'b1; bus.valor = 16'h5678; ciclo();
    bus.cargar = 1'b0;
    chk_out("t5_load", 4'h6, 4'hB, 3'd2, 1'b0);
    ciclo(); chk_out("t5_hold", 4'h6, 4'hB, 3'd2, 1'b0);
    ciclo(); chk_out("t5_adv", 4'h5, 4'h7, 3'd3, 1'b1);

    // Reset mid-scan at idx=3, cont=2
    repeat (2) ciclo();
    rst = 1'b1; ciclo();
    chk_out("t6_rst", 4'h0, 4'hF, 3'd0, 1'b0);
    rst = 1'b0; ciclo();
    chk_out("t6_rel", 4'h0, 4'hE, 3'd0, 1'b0);
    repeat (2) ciclo();
    chk_out("t6_k3", 4'h0, 4'hE, 3'd0, 1'b0);
    ciclo();
    chk_out("t6_k4", 4'h0, 4'hD, 3'd1, 1'b1);

    // Randomized traffic against the model, both configurations
    rst = 1'b1; ciclo(); check_model("rnd_rst");
    rst = 1'b0;
    repeat (800) begin
      rst        = ($urandom_range(0, 63) == 0);
      bus.cargar = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) bus.supr_ceros = ~bus.supr_ceros;
      bus.valor  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      ciclo();
      check_model("rnd");
      if ($urandom_range(0, 9) == 0) begin
        bus.supr_ceros = ~bus.supr_ceros; #1;
        check_model("rnd_supr");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
